// File: rtl/core_clk_rst_pkg.sv
// Shared types and defaults for the core clock/reset sequencer.
package core_clk_rst_pkg;

   // Sequencer states; encoding is visible on the debug port.
   typedef enum logic [1:0] {
      S_WAIT = 2'd0,
      S_STAB = 2'd1,
      S_RUN  = 2'd2,
      S_HOLD = 2'd3
   } seq_state_t;

   // Default timing for the 39.936 MHz PLL clock.
   localparam int DEF_STABLE_CYCLES = 4096;
   localparam int DEF_HOLD_CYCLES   = 16;
   localparam int DEF_PIX_DIV       = 6;
   localparam int DEF_CPU_DIV       = 12;

   // Counter width for a modulo-n count; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous level inputs.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the asynchronous input through two flops to settle metastability.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let both flops sample the old values, forming a true two-stage shift.
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/core_clk_rst_seq.sv
// Reset sequencer and pixel/CPU clock-enable generator behind the core PLL.
// Holds the core in reset until lock is stable, then runs the enables;
// re-enters reset on lock loss or soft reset.
module core_clk_rst_seq
   import core_clk_rst_pkg::*;
#(
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int PIX_DIV       = DEF_PIX_DIV,
   parameter int CPU_DIV       = DEF_CPU_DIV
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       soft_rst,
   output logic       core_rst_n,
   output logic       ce_pix,
   output logic       ce_cpu,
   output logic       lock_lost,
   output logic [1:0] state
);

   localparam int STAB_W = cnt_width(STABLE_CYCLES);
   localparam int HOLD_W = cnt_width(HOLD_CYCLES);
   localparam int PIX_W  = cnt_width(PIX_DIV);
   localparam int CPU_W  = cnt_width(CPU_DIV);

   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_DIV - 1);
   localparam logic [CPU_W-1:0]  CPU_LAST  = CPU_W'(CPU_DIV - 1);

   seq_state_t        st;
   logic              locked_s;
   logic [STAB_W-1:0] stab_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [PIX_W-1:0]  pix_cnt;
   logic [CPU_W-1:0]  cpu_cnt;

   sync_2ff u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (locked_s)
   );

   assign state = st;

   // Sequencer FSM with its counters and registered outputs, all updated on one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every flop here is reset asynchronously so the core sees reset with no clock running.
      if (!rst_n) begin
         st         <= S_WAIT;
         stab_cnt   <= '0;
         hold_cnt   <= '0;
         pix_cnt    <= '0;
         cpu_cnt    <= '0;
         core_rst_n <= 1'b0;
         ce_pix     <= 1'b0;
         ce_cpu     <= 1'b0;
         lock_lost  <= 1'b0;
      end else begin
         ce_pix <= 1'b0;
         ce_cpu <= 1'b0;
         case (st)
            S_WAIT: begin
               stab_cnt   <= '0;
               hold_cnt   <= '0;
               pix_cnt    <= '0;
               cpu_cnt    <= '0;
               core_rst_n <= 1'b0;
               if (locked_s) st <= S_STAB;
            end
            S_STAB: begin
               if (!locked_s) begin
                  st       <= S_WAIT;
                  stab_cnt <= '0;
               end else if (stab_cnt == STAB_LAST) begin
                  st         <= S_RUN;
                  stab_cnt   <= '0;
                  core_rst_n <= 1'b1;
                  pix_cnt    <= '0;
                  cpu_cnt    <= '0;
               end else begin
                  stab_cnt <= stab_cnt + 1'b1;
               end
            end
            S_RUN: begin
               if (!locked_s) begin
                  st         <= S_WAIT;
                  lock_lost  <= 1'b1;
                  core_rst_n <= 1'b0;
               end else if (soft_rst) begin
                  st         <= S_HOLD;
                  hold_cnt   <= '0;
                  core_rst_n <= 1'b0;
               end else begin
                  pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + 1'b1;
                  cpu_cnt <= (cpu_cnt == CPU_LAST) ? '0 : cpu_cnt + 1'b1;
                  ce_pix  <= (pix_cnt == PIX_LAST);
                  ce_cpu  <= (cpu_cnt == CPU_LAST);
               end
            end
            S_HOLD: begin
               // Lock loss outranks a concurrent soft-reset request.
               if (!locked_s) begin
                  st         <= S_WAIT;
                  lock_lost  <= 1'b1;
                  core_rst_n <= 1'b0;
               end else if (soft_rst) begin
                  hold_cnt <= '0;
               end else if (hold_cnt == HOLD_LAST) begin
                  st         <= S_RUN;
                  hold_cnt   <= '0;
                  core_rst_n <= 1'b1;
                  pix_cnt    <= '0;
                  cpu_cnt    <= '0;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               st         <= S_WAIT;
               core_rst_n <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_clk_rst_seq.sv
// Self-checking bench for core_clk_rst_seq: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
module tb_core_clk_rst_seq;

   localparam int STABLE = 16;
   localparam int HOLD   = 4;
   localparam int PIX    = 6;
   localparam int CPU    = 12;

   localparam int M_WAIT = 0;
   localparam int M_STAB = 1;
   localparam int M_RUN  = 2;
   localparam int M_HOLD = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_locked;
   logic       soft_rst;
   logic       core_rst_n;
   logic       ce_pix;
   logic       ce_cpu;
   logic       lock_lost;
   logic [1:0] state;

   int tests_run = 0;
   int failures  = 0;

   core_clk_rst_seq #(
      .STABLE_CYCLES (STABLE),
      .HOLD_CYCLES   (HOLD),
      .PIX_DIV       (PIX),
      .CPU_DIV       (CPU)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pll_locked (pll_locked),
      .soft_rst   (soft_rst),
      .core_rst_n (core_rst_n),
      .ce_pix     (ce_pix),
      .ce_cpu     (ce_cpu),
      .lock_lost  (lock_lost),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      tests_run++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Mode, time spent in the current stability/hold window, and cycles since
   // RUN was entered. Enables follow from run age by plain modulo arithmetic.
   int m_mode    = M_WAIT;
   int m_age     = 0;
   int m_run_age = 0;
   bit m_lost    = 1'b0;
   bit m_hist1   = 1'b0;
   bit m_hist2   = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      bit l;
      if (!rst_n) begin
         m_mode = M_WAIT; m_age = 0; m_run_age = 0; m_lost = 1'b0;
         m_hist1 = 1'b0; m_hist2 = 1'b0;
      end else begin
         l = m_hist2;
         m_hist2 = m_hist1;
         m_hist1 = pll_locked;
         if (m_mode == M_WAIT) begin
            if (l) begin m_mode = M_STAB; m_age = 0; end
         end else if (m_mode == M_STAB) begin
            if (!l) m_mode = M_WAIT;
            else if (m_age == STABLE - 1) begin m_mode = M_RUN; m_run_age = 0; end
            else m_age++;
         end else if (m_mode == M_RUN) begin
            if (!l) begin m_mode = M_WAIT; m_lost = 1'b1; end
            else if (soft_rst) begin m_mode = M_HOLD; m_age = 0; end
            else m_run_age++;
         end else begin
            if (!l) begin m_mode = M_WAIT; m_lost = 1'b1; end
            else if (soft_rst) m_age = 0;
            else if (m_age == HOLD - 1) begin m_mode = M_RUN; m_run_age = 0; end
            else m_age++;
         end
      end
   end

   function automatic bit exp_ce(input int div);
      return (m_mode == M_RUN) && (m_run_age > 0) && (m_run_age % div == 0);
   endfunction

   // Per-cycle comparison of every output against the model.
   bit cmp_en = 1'b0;
   always @(negedge clk) begin
      if (cmp_en && rst_n) begin
         check("model_state", 32'(state), 32'(m_mode));
         check("model_core_rst_n", 32'(core_rst_n), 32'(m_mode == M_RUN));
         check("model_ce_pix", 32'(ce_pix), 32'(exp_ce(PIX)));
         check("model_ce_cpu", 32'(ce_cpu), 32'(exp_ce(CPU)));
         check("model_lock_lost", 32'(lock_lost), 32'(m_lost));
      end
   end

   // Bounded wait for the DUT to reach a given state; timeout counts as a failure.
   task automatic wait_state(input int target, input int budget, input string name);
      int n = 0;
      while (32'(state) != target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(state), 32'(target));
   endtask

   int low_left;
   int low_cnt;

   initial begin
      rst_n = 1'b0;
      pll_locked = 1'b1;
      soft_rst = 1'b0;
      #3;
      check("rst_state", 32'(state), 32'd0);
      check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
      check("rst_ce_pix", 32'(ce_pix), 32'd0);
      check("rst_ce_cpu", 32'(ce_cpu), 32'd0);
      check("rst_lock_lost", 32'(lock_lost), 32'd0);

      // Reset release with lock already high: STAB at edge 3, RUN at edge 19.
      @(negedge clk);
      rst_n = 1'b1;
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);
      check("edge2_state", 32'(state), 32'd0);
      @(negedge clk);
      check("edge3_state", 32'(state), 32'd1);
      repeat (15) @(negedge clk);
      check("edge18_core_rst_n", 32'(core_rst_n), 32'd0);
      @(negedge clk);
      check("edge19_core_rst_n", 32'(core_rst_n), 32'd1);
      check("edge19_state", 32'(state), 32'd2);
      repeat (5) @(negedge clk);
      check("edge24_ce_pix", 32'(ce_pix), 32'd0);
      @(negedge clk);
      check("edge25_ce_pix", 32'(ce_pix), 32'd1);
      check("edge25_ce_cpu", 32'(ce_cpu), 32'd0);
      repeat (6) @(negedge clk);
      check("edge31_ce_pix", 32'(ce_pix), 32'd1);
      check("edge31_ce_cpu", 32'(ce_cpu), 32'd1);
      repeat (10) @(negedge clk);

      // Lock loss in RUN: reset and flag follow three edges after the drop.
      pll_locked = 1'b0;
      repeat (2) @(negedge clk);
      check("loss_core_still_high", 32'(core_rst_n), 32'd1);
      @(negedge clk);
      check("loss_core_rst_n", 32'(core_rst_n), 32'd0);
      check("loss_lock_lost", 32'(lock_lost), 32'd1);
      check("loss_ce_pix", 32'(ce_pix), 32'd0);
      check("loss_state", 32'(state), 32'd0);
      pll_locked = 1'b1;
      wait_state(M_RUN, 100, "relock_run");
      check("relock_lock_lost", 32'(lock_lost), 32'd1);

      // One-cycle glitch at stability count 10 restarts the full count.
      pll_locked = 1'b0;
      repeat (4) @(negedge clk);
      pll_locked = 1'b1;
      wait_state(M_STAB, 20, "glitch_reach_stab");
      repeat (10) @(negedge clk);
      pll_locked = 1'b0;
      @(negedge clk);
      pll_locked = 1'b1;
      repeat (2) @(negedge clk);
      check("glitch_wait", 32'(state), 32'd0);
      repeat (16) @(negedge clk);
      check("glitch_stab_end", 32'(state), 32'd1);
      check("glitch_core_low", 32'(core_rst_n), 32'd0);
      @(negedge clk);
      check("glitch_run", 32'(state), 32'd2);
      repeat (9) @(negedge clk);

      // One-cycle soft reset: core reset low for exactly HOLD cycles.
      soft_rst = 1'b1;
      @(negedge clk);
      soft_rst = 1'b0;
      check("soft_hold_state", 32'(state), 32'd3);
      low_cnt = (core_rst_n == 1'b0) ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (core_rst_n == 1'b0) low_cnt++;
      end
      check("soft_low_cycles", 32'(low_cnt), 32'd4);
      check("soft_back_run", 32'(state), 32'd2);
      repeat (5) @(negedge clk);
      check("soft_pix_pre", 32'(ce_pix), 32'd0);
      @(negedge clk);
      check("soft_pix_first", 32'(ce_pix), 32'd1);
      repeat (4) @(negedge clk);

      // Soft reset held in HOLD while lock loss arrives: lock loss wins.
      soft_rst = 1'b1;
      @(negedge clk);
      pll_locked = 1'b0;
      repeat (2) @(negedge clk);
      check("combo_still_hold", 32'(state), 32'd3);
      @(negedge clk);
      check("combo_wait", 32'(state), 32'd0);
      check("combo_lock_lost", 32'(lock_lost), 32'd1);
      soft_rst = 1'b0;
      pll_locked = 1'b1;
      wait_state(M_RUN, 100, "combo_relock");

      // Asynchronous reset mid-RUN clears everything without a clock edge.
      repeat (3) @(negedge clk);
      check("pre_rst_lock_lost", 32'(lock_lost), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_state", 32'(state), 32'd0);
      check("async_core_rst_n", 32'(core_rst_n), 32'd0);
      check("async_ce_pix", 32'(ce_pix), 32'd0);
      check("async_ce_cpu", 32'(ce_cpu), 32'd0);
      check("async_lock_lost", 32'(lock_lost), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized lock dropouts and soft-reset requests against the model.
      low_left = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (low_left > 0) low_left--;
         else if ($urandom_range(0, 199) == 0) low_left = $urandom_range(1, 6);
         pll_locked = (low_left == 0);
         soft_rst = ($urandom_range(0, 39) == 0);
      end
      soft_rst = 1'b0;
      pll_locked = 1'b1;
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
